td_fifo_reader: RTL and testbench

Consumer-side front end for the TaggedDirection BRAM FIFO. Issues read strobes into the FIFO, absorbs its one-cycle registered read latency, and re-times entries onto a ready/valid stream toward the traversal unit. Stalls on downstream backpressure without losing or reordering entries. Sustains one entry per cycle when neither side stalls.

---
 rtl/td_fifo_reader_pkg.sv | 32 +++
 rtl/td_skid2.sv | 81 ++++++++
 rtl/td_fifo_reader.sv | 75 +++++++
 tb/tb_td_fifo_reader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td_fifo_reader_pkg.sv
// Shared types for the TaggedDirection FIFO consumer path.
//   tagged_direction_t : one FIFO entry {tag, x, y, z}, tag in the MSBs
//   TD_SKID_DEPTH      : number of entries held by the reader's skid buffer
//   OCC_*              : skid-buffer occupancy encodings
//   td_pending         : entries owned by the reader once this cycle's pop retires
package td_fifo_reader_pkg;

  localparam int unsigned TD_WIDTH    = 16;
  localparam int unsigned TD_TAG_SIZE = 8;

  typedef struct packed {
    logic [TD_TAG_SIZE-1:0] tag;
    logic [TD_WIDTH-1:0]    x;
    logic [TD_WIDTH-1:0]    y;
    logic [TD_WIDTH-1:0]    z;
  } tagged_direction_t;

  localparam int unsigned TD_SKID_DEPTH = 2;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Buffered entries plus the read in flight, less the entry leaving this cycle.
  // A pop only happens with a non-empty buffer, so this never underflows.
  function automatic logic [2:0] td_pending(input logic [1:0] occ,
                                            input logic       inflight,
                                            input logic       pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/td_skid2.sv
// Two-entry ordered register buffer.
//   push  : store din behind the current contents
//   pop   : retire the head entry
//   flush : empty the buffer at the next edge; overrides push
//   occ   : occupancy (OCC_EMPTY / OCC_ONE / OCC_TWO)
//   head  : oldest entry; holds its value while no pop occurs
module td_skid2
  import td_fifo_reader_pkg::*;
#(
  parameter int unsigned DW = $bits(tagged_direction_t)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] e0_q, e0_d;
  logic [DW-1:0] e1_q, e1_d;
  logic [1:0]    occ_q, occ_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            e0_d  = din;
            occ_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            e0_d = din;
          end else if (push) begin
            e1_d  = din;
            occ_d = OCC_TWO;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Push without pop cannot occur here: the issue rule upstream prevents it.
          if (pop) begin
            e0_d = e1_q;
            if (push) begin
              e1_d = din;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= OCC_EMPTY;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/td_fifo_reader.sv
// Consumer-side front end for the TaggedDirection BRAM FIFO. Issues reads, absorbs the
// FIFO's one-cycle read latency and presents entries on a ready/valid stream.
//   clk, reset_n        : clock, asynchronous active-low reset
//   fifo_ready          : FIFO non-empty
//   fifo_read           : read strobe (combinational)
//   fifo_dir            : FIFO read data, valid the cycle after fifo_read
//   m_valid/m_ready/m_dir : output stream; m_dir is the skid-buffer head
//   flush               : drop buffered and in-flight entries
//   delivered           : handshake counter, wraps modulo 2^CNT_W
// Data ports are flat vectors laid out as tagged_direction_t ({tag, x, y, z}).
module td_fifo_reader
  import td_fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH    = TD_WIDTH,
  parameter int unsigned TAG_SIZE = TD_TAG_SIZE,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        fifo_ready,
  output logic                        fifo_read,
  input  logic [3*WIDTH+TAG_SIZE-1:0] fifo_dir,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [3*WIDTH+TAG_SIZE-1:0] m_dir,
  input  logic                        flush,
  output logic [CNT_W-1:0]            delivered
);

  localparam int unsigned DW = 3 * WIDTH + TAG_SIZE;

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] delivered_q, delivered_d;
  logic [1:0]       occ;
  logic             pop;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid && m_ready;

  // The pop term lets reads resume in the same cycle backpressure releases.
  // Gating with reset_n keeps the strobe low while the FIFO is also held in reset.
  assign fifo_read = reset_n && fifo_ready && !flush &&
                     (td_pending(occ, inflight_q, pop) < 3'(TD_SKID_DEPTH));

  // fifo_read is already low during a flush, so this also clears the in-flight flag.
  assign inflight_d  = fifo_read;
  assign delivered_d = delivered_q + CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q  <= 1'b0;
      delivered_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      delivered_q <= delivered_d;
    end
  end

  assign delivered = delivered_q;

  // The FIFO's valid_out is sticky, so capture is driven by our own in-flight flag.
  td_skid2 #(
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight_q),
    .pop     (pop),
    .flush   (flush),
    .din     (fifo_dir),
    .occ     (occ),
    .head    (m_dir)
  );

endmodule

// File: tb/tb_td_fifo_reader.sv
module tb_td_fifo_reader;
  import td_fifo_reader_pkg::*;

  localparam int DW = $bits(tagged_direction_t);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_en = 1'b0;
  logic          fifo_ready;
  logic          fifo_read, fifo_read4;
  logic [DW-1:0] fifo_dir;
  logic          m_valid, m_valid4;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_dir, m_dir4;
  logic          flush = 1'b0;
  logic [31:0]   delivered;
  logic [3:0]    delivered4;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_mem [32];
  int         rd_ptr;
  int         wr_ptr = 0;
  logic       overrun_seen = 1'b0;

  always #5 clk = ~clk;

  td_fifo_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_ready (fifo_ready),
    .fifo_read  (fifo_read),
    .fifo_dir   (fifo_dir),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_dir      (m_dir),
    .flush      (flush),
    .delivered  (delivered)
  );

  td_fifo_reader #(
    .CNT_W (4)
  ) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_ready (fifo_ready),
    .fifo_read  (fifo_read4),
    .fifo_dir   (fifo_dir),
    .m_valid    (m_valid4),
    .m_ready    (m_ready),
    .m_dir      (m_dir4),
    .flush      (flush),
    .delivered  (delivered4)
  );

  function automatic tagged_direction_t make_dir(input logic [7:0] t);
    tagged_direction_t d;
    d.tag = t;
    d.x   = {8'h10, t};
    d.y   = {8'h20, t};
    d.z   = {8'h30, t};
    return d;
  endfunction

  // FIFO model: registered read data, reset together with the reader.
  assign fifo_ready = fifo_en && (rd_ptr != wr_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= 0;
      fifo_dir <= '0;
    end else if (fifo_read) begin
      fifo_dir <= make_dir(fifo_mem[rd_ptr[4:0]]);
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // A capture into a full buffer with no pop would lose an entry.
  always @(negedge clk) begin
    if (reset_n && dut.inflight_q && dut.u_skid.occ_q == OCC_TWO && !(m_valid && m_ready))
      overrun_seen <= 1'b1;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    fifo_en = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    wr_ptr  = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr[4:0]] = 8'(first + i);
      wr_ptr++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_ptr  = 0;
    preload(1, 1);
    fifo_en = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++; $display("FAIL reset_fifo_read got %b want 0", fifo_read);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid got %b want 0", m_valid);
    end
    checks++;
    if (m_dir !== '0) begin
      errors++; $display("FAIL reset_m_dir got %h want 0", m_dir);
    end
    checks++;
    if (delivered !== 32'd0) begin
      errors++; $display("FAIL reset_delivered got %0d want 0", delivered);
    end
    checks++;
    if (delivered4 !== 4'd0) begin
      errors++; $display("FAIL reset_delivered4 got %0d want 0", delivered4);
    end
  endtask

  task automatic test_steady();
    logic [11:0] exp_rd, exp_vl;
    exp_rd = 12'h0FF;
    exp_vl = 12'h3FC;
    do_reset();
    preload(1, 8);
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
      #2;
      checks++;
      if (fifo_read !== exp_rd[c]) begin
        errors++; $display("FAIL steady_read c=%0d got %b want %b", c, fifo_read, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_vl[c]) begin
        errors++; $display("FAIL steady_valid c=%0d got %b want %b", c, m_valid, exp_vl[c]);
      end
      if (exp_vl[c]) begin
        checks++;
        if (m_dir !== make_dir(8'(c - 1))) begin
          errors++; $display("FAIL steady_dir c=%0d got %h want %h", c, m_dir, make_dir(8'(c - 1)));
        end
      end
    end
    checks++;
    if (delivered !== 32'd8) begin
      errors++; $display("FAIL steady_delivered got %0d want 8", delivered);
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_rd, exp_vl;
    int          exp_tag [17];
    exp_rd  = 17'h03C0F;
    exp_vl  = 17'h0FFFC;
    exp_tag = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 0};
    do_reset();
    preload(1, 8);
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
      m_ready = !(c >= 4 && c <= 9);
      #2;
      checks++;
      if (fifo_read !== exp_rd[c]) begin
        errors++; $display("FAIL bp_read c=%0d got %b want %b", c, fifo_read, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_vl[c]) begin
        errors++; $display("FAIL bp_valid c=%0d got %b want %b", c, m_valid, exp_vl[c]);
      end
      if (exp_vl[c]) begin
        checks++;
        if (m_dir !== make_dir(8'(exp_tag[c]))) begin
          errors++; $display("FAIL bp_dir c=%0d got %h want tag %0d", c, m_dir, exp_tag[c]);
        end
      end
      if (c == 9) begin
        checks++;
        if (dut.u_skid.occ_q !== OCC_TWO) begin
          errors++; $display("FAIL bp_occupancy got %0d want 2", dut.u_skid.occ_q);
        end
      end
    end
    checks++;
    if (delivered !== 32'd8) begin
      errors++; $display("FAIL bp_delivered got %0d want 8", delivered);
    end
  endtask

  task automatic test_sparse();
    logic [13:0] exp_rd, exp_vl;
    exp_rd = 14'h0249;
    exp_vl = 14'h0924;
    do_reset();
    preload(1, 4);
    m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      fifo_en = (c % 3 == 0);
      #2;
      checks++;
      if (fifo_read !== exp_rd[c]) begin
        errors++; $display("FAIL sparse_read c=%0d got %b want %b", c, fifo_read, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_vl[c]) begin
        errors++; $display("FAIL sparse_valid c=%0d got %b want %b", c, m_valid, exp_vl[c]);
      end
      if (exp_vl[c]) begin
        checks++;
        if (m_dir !== make_dir(8'((c + 1) / 3))) begin
          errors++; $display("FAIL sparse_dir c=%0d got %h want tag %0d", c, m_dir, (c + 1) / 3);
        end
      end
    end
    checks++;
    if (delivered !== 32'd4) begin
      errors++; $display("FAIL sparse_delivered got %0d want 4", delivered);
    end
  endtask

  task automatic test_flush();
    logic [9:0] exp_rd, exp_vl;
    exp_rd = 10'h07D;
    exp_vl = 10'h1F0;
    do_reset();
    preload(1, 6);
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
      flush   = (c == 1);
      #2;
      checks++;
      if (fifo_read !== exp_rd[c]) begin
        errors++; $display("FAIL flush_read c=%0d got %b want %b", c, fifo_read, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_vl[c]) begin
        errors++; $display("FAIL flush_valid c=%0d got %b want %b", c, m_valid, exp_vl[c]);
      end
      if (exp_vl[c]) begin
        checks++;
        if (m_dir !== make_dir(8'(c - 2))) begin
          errors++; $display("FAIL flush_dir c=%0d got %h want tag %0d", c, m_dir, c - 2);
        end
      end
    end
    flush = 1'b0;
    checks++;
    if (delivered !== 32'd5) begin
      errors++; $display("FAIL flush_delivered got %0d want 5", delivered);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    preload(1, 8);
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++; $display("FAIL areset_read got %b want 0", fifo_read);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL areset_valid got %b want 0", m_valid);
    end
    checks++;
    if (m_dir !== '0) begin
      errors++; $display("FAIL areset_dir got %h want 0", m_dir);
    end
    checks++;
    if (delivered !== 32'd0) begin
      errors++; $display("FAIL areset_delivered got %0d want 0", delivered);
    end
    fifo_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #3;
      checks++;
      if (fifo_read !== 1'b0 || m_valid !== 1'b0) begin
        errors++; $display("FAIL areset_idle c=%0d got read %b valid %b want 0 0",
                           c, fifo_read, m_valid);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
      #2;
      if (c == 0) begin
        checks++;
        if (fifo_read !== 1'b1) begin
          errors++; $display("FAIL areset_resume_read got %b want 1", fifo_read);
        end
      end
      if (c == 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_dir !== make_dir(8'd1)) begin
          errors++; $display("FAIL areset_resume_dir got valid %b dir %h want 1 %h",
                             m_valid, m_dir, make_dir(8'd1));
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    preload(1, 17);
    m_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      fifo_en = 1'b1;
    end
    #2;
    checks++;
    if (delivered4 !== 4'd1) begin
      errors++; $display("FAIL wrap_delivered4 got %0d want 1", delivered4);
    end
    checks++;
    if (delivered !== 32'd17) begin
      errors++; $display("FAIL wrap_delivered32 got %0d want 17", delivered);
    end
  endtask

  task automatic test_no_overrun();
    checks++;
    if (overrun_seen !== 1'b0) begin
      errors++; $display("FAIL no_overrun got %b want 0", overrun_seen);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_sparse();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    test_no_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
